// File: rtl/conv_layer_mem.sv
// conv_layer_mem: five 20-bit layer banks behind the CONV csel/crd/cwr port, plus a
// ready/valid dump streamer. Optional macro CONV_MEM_BYPASS_EN enables write-first forwarding.
module conv_layer_mem #(
   parameter int DW   = 20,
   parameter int AW   = 12,
   parameter int L0_D = 4096,
   parameter int L1_D = 1024,
   parameter int L2_D = 2048
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    csel,
   input  logic          crd,
   input  logic [AW-1:0] caddr_rd,
   output logic [DW-1:0] cdata_rd,
   input  logic          cwr,
   input  logic [AW-1:0] caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   output logic [2:0]    wr_seen,
   output logic          addr_err,
   input  logic          dump_start,
   input  logic [2:0]    dump_sel,
   output logic          dump_valid,
   input  logic          dump_ready,
   output logic [AW-1:0] dump_addr,
   output logic [DW-1:0] dump_data,
   output logic          dump_busy
);

   localparam int L0_AW = $clog2(L0_D);
   localparam int L1_AW = $clog2(L1_D);
   localparam int L2_AW = $clog2(L2_D);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RD    = 2'd1,
      ST_VALID = 2'd2
   } dump_state_t;

   logic [DW-1:0] mem_l0k0_r [L0_D];
   logic [DW-1:0] mem_l0k1_r [L0_D];
   logic [DW-1:0] mem_l1k0_r [L1_D];
   logic [DW-1:0] mem_l1k1_r [L1_D];
   logic [DW-1:0] mem_l2_r   [L2_D];

   logic [DW-1:0] cdata_rd_r;
   logic [2:0]    wr_seen_r;
   logic          addr_err_r;
   logic          rd_ok_s;
   logic          wr_ok_s;
   logic          err_s;
   logic [DW-1:0] conv_rd_data_s;

   dump_state_t   state_r;
   dump_state_t   state_nxt_s;
   logic [2:0]    dump_sel_r;
   logic [AW-1:0] dump_addr_r;
   logic [DW-1:0] dump_data_r;
   logic          dump_valid_r;
   logic          dump_busy_r;
   logic          dump_stall_s;
   logic          dump_last_s;
   logic          dump_fwd_s;
   logic [DW-1:0] dump_rd_data_s;
   logic          start_s;
   logic          load_s;
   logic          adv_s;
   logic          done_s;
   logic          dump_sel_err_s;

   // Depth of the bank addressed by a select code; zero marks an invalid select.
   function automatic int bank_depth(input logic [2:0] sel);
      case (sel)
         3'b001, 3'b010: bank_depth = L0_D;
         3'b011, 3'b100: bank_depth = L1_D;
         3'b101:         bank_depth = L2_D;
         default:        bank_depth = 32'sd0;
      endcase
   endfunction

   // True when sel names a real bank and addr lies inside it.
   function automatic logic addr_ok(input logic [2:0] sel, input logic [AW-1:0] addr);
      addr_ok = (int'({1'b0, addr}) < bank_depth(sel));
   endfunction

   // Layer flag for the wr_seen register.
   function automatic logic [2:0] layer_bit(input logic [2:0] sel);
      case (sel)
         3'b001, 3'b010: layer_bit = 3'b001;
         3'b011, 3'b100: layer_bit = 3'b010;
         3'b101:         layer_bit = 3'b100;
         default:        layer_bit = 3'b000;
      endcase
   endfunction

   // Array read of one bank; callers gate the result with addr_ok.
   function automatic logic [DW-1:0] bank_word(input logic [2:0] sel, input logic [AW-1:0] addr);
      case (sel)
         3'b001:  bank_word = mem_l0k0_r[addr[L0_AW-1:0]];
         3'b010:  bank_word = mem_l0k1_r[addr[L0_AW-1:0]];
         3'b011:  bank_word = mem_l1k0_r[addr[L1_AW-1:0]];
         3'b100:  bank_word = mem_l1k1_r[addr[L1_AW-1:0]];
         3'b101:  bank_word = mem_l2_r[addr[L2_AW-1:0]];
         default: bank_word = {DW{1'b0}};
      endcase
   endfunction

   assign rd_ok_s      = crd & addr_ok(csel, caddr_rd);
   assign wr_ok_s      = cwr & addr_ok(csel, caddr_wr);
   assign err_s        = (crd & ~addr_ok(csel, caddr_rd)) | (cwr & ~addr_ok(csel, caddr_wr)) |
                         dump_sel_err_s;
   // The CONV port owns the bank this cycle whenever it touches the dump bank.
   assign dump_stall_s = (crd | cwr) & (csel == dump_sel_r);
   assign dump_last_s  = (int'({1'b0, dump_addr_r}) == (bank_depth(dump_sel_r) - 32'sd1));
   assign dump_fwd_s   = wr_ok_s & (csel == dump_sel_r) & (caddr_wr == dump_addr_r);

   // CONV read data: zero for rejected reads, optional write-first forwarding.
   always_comb begin
      conv_rd_data_s = {DW{1'b0}};
      if (rd_ok_s) begin
`ifdef CONV_MEM_BYPASS_EN
         conv_rd_data_s = (wr_ok_s && (caddr_wr == caddr_rd)) ? cdata_wr : bank_word(csel, caddr_rd);
`else
         conv_rd_data_s = bank_word(csel, caddr_rd);
`endif
      end else begin
         conv_rd_data_s = {DW{1'b0}};
      end
   end

   // Dump read data for the word at dump_addr.
   always_comb begin
      dump_rd_data_s = {DW{1'b0}};
`ifdef CONV_MEM_BYPASS_EN
      dump_rd_data_s = dump_fwd_s ? cdata_wr : bank_word(dump_sel_r, dump_addr_r);
`else
      dump_rd_data_s = bank_word(dump_sel_r, dump_addr_r);
`endif
   end

   // Bank storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         case (csel)
            3'b001:  mem_l0k0_r[caddr_wr[L0_AW-1:0]] <= cdata_wr;
            3'b010:  mem_l0k1_r[caddr_wr[L0_AW-1:0]] <= cdata_wr;
            3'b011:  mem_l1k0_r[caddr_wr[L1_AW-1:0]] <= cdata_wr;
            3'b100:  mem_l1k1_r[caddr_wr[L1_AW-1:0]] <= cdata_wr;
            3'b101:  mem_l2_r[caddr_wr[L2_AW-1:0]]   <= cdata_wr;
            default: ;
         endcase
      end
   end

   // CONV read register and sticky status flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cdata_rd_r <= {DW{1'b0}};
         wr_seen_r  <= 3'b000;
         addr_err_r <= 1'b0;
      end else begin
         if (crd) begin
            cdata_rd_r <= conv_rd_data_s;
         end
         if (wr_ok_s) begin
            wr_seen_r <= wr_seen_r | layer_bit(csel);
         end
         if (err_s) begin
            addr_err_r <= 1'b1;
         end
      end
   end

   // Dump FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Dump FSM next state and datapath strobes.
   always_comb begin
      state_nxt_s    = state_r;
      start_s        = 1'b0;
      load_s         = 1'b0;
      adv_s          = 1'b0;
      done_s         = 1'b0;
      dump_sel_err_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (dump_start) begin
               if (bank_depth(dump_sel) != 32'sd0) begin
                  start_s     = 1'b1;
                  state_nxt_s = ST_RD;
               end else begin
                  dump_sel_err_s = 1'b1;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RD: begin
            if (!dump_stall_s) begin
               load_s      = 1'b1;
               state_nxt_s = ST_VALID;
            end else begin
               state_nxt_s = ST_RD;
            end
         end
         ST_VALID: begin
            if (dump_ready) begin
               if (dump_last_s) begin
                  done_s      = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  adv_s       = 1'b1;
                  state_nxt_s = ST_RD;
               end
            end else begin
               state_nxt_s = ST_VALID;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Dump datapath registers driven by the FSM strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dump_sel_r   <= 3'b000;
         dump_addr_r  <= {AW{1'b0}};
         dump_data_r  <= {DW{1'b0}};
         dump_valid_r <= 1'b0;
         dump_busy_r  <= 1'b0;
      end else begin
         if (start_s) begin
            dump_sel_r  <= dump_sel;
            dump_addr_r <= {AW{1'b0}};
            dump_busy_r <= 1'b1;
         end
         if (load_s) begin
            dump_data_r  <= dump_rd_data_s;
            dump_valid_r <= 1'b1;
         end
         if (adv_s) begin
            dump_addr_r  <= dump_addr_r + {{(AW-1){1'b0}}, 1'b1};
            dump_valid_r <= 1'b0;
         end
         if (done_s) begin
            dump_valid_r <= 1'b0;
            dump_busy_r  <= 1'b0;
         end
      end
   end

   assign cdata_rd   = cdata_rd_r;
   assign wr_seen    = wr_seen_r;
   assign addr_err   = addr_err_r;
   assign dump_valid = dump_valid_r;
   assign dump_addr  = dump_addr_r;
   assign dump_data  = dump_data_r;
   assign dump_busy  = dump_busy_r;

endmodule

// File: tb/tb_conv_layer_mem.sv
// Scoreboard bench for conv_layer_mem: stimulus pushes expected CONV reads and dump
// words into queues; monitors pop and compare when the DUT presents them.
module tb_conv_layer_mem;

   localparam int DW = 20;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    csel;
   logic          crd;
   logic [AW-1:0] caddr_rd;
   logic [DW-1:0] cdata_rd;
   logic          cwr;
   logic [AW-1:0] caddr_wr;
   logic [DW-1:0] cdata_wr;
   logic [2:0]    wr_seen;
   logic          addr_err;
   logic          dump_start;
   logic [2:0]    dump_sel;
   logic          dump_valid;
   logic          dump_ready;
   logic [AW-1:0] dump_addr;
   logic [DW-1:0] dump_data;
   logic          dump_busy;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0]    rd_exp_q[$];
   logic [AW+DW-1:0] dump_exp_q[$];
   logic             hold_f = 1'b0;
   logic [31:0]      hold_v = 32'd0;

   conv_layer_mem dut (
      .clk(clk), .reset(reset), .csel(csel), .crd(crd), .caddr_rd(caddr_rd),
      .cdata_rd(cdata_rd), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
      .wr_seen(wr_seen), .addr_err(addr_err), .dump_start(dump_start),
      .dump_sel(dump_sel), .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // CONV read monitor: one expected word per accepted crd
   always @(posedge clk) begin
      if (reset === 1'b1 && crd === 1'b1) begin
         #1;
         if (rd_exp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
         else check("cdata_rd", 32'(cdata_rd), 32'(rd_exp_q.pop_front()));
      end
   end

   // Dump monitor: compare accepted words, and stability while stalled
   always @(posedge clk) begin
      if (reset !== 1'b1) begin
         hold_f = 1'b0;
      end else begin
         if (hold_f && dump_valid === 1'b1) check("dump_stable", {dump_addr, dump_data}, hold_v);
         hold_f = 1'b0;
         if (dump_valid === 1'b1) begin
            if (dump_ready === 1'b1) begin
               if (dump_exp_q.size() == 0) check("dump_unexpected", 32'd1, 32'd0);
               else check("dump_word", {dump_addr, dump_data}, dump_exp_q.pop_front());
            end else begin
               hold_f = 1'b1;
               hold_v = {dump_addr, dump_data};
            end
         end
      end
   end

   task automatic write_word(input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      csel = s; cwr = 1'b1; caddr_wr = a; cdata_wr = d; crd = 1'b0;
      @(negedge clk);
      cwr = 1'b0;
   endtask

   task automatic read_word(input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] e);
      @(negedge clk);
      csel = s; crd = 1'b1; caddr_rd = a; cwr = 1'b0;
      rd_exp_q.push_back(e);
      @(negedge clk);
      crd = 1'b0;
   endtask

   task automatic start_dump(input logic [2:0] s);
      @(negedge clk);
      dump_start = 1'b1; dump_sel = s;
      @(negedge clk);
      dump_start = 1'b0;
   endtask

   // Waits for dump_busy to fall, with a cycle budget
   task automatic wait_dump_done(input string name, input int limit);
      int c;
      c = 0;
      while (dump_busy === 1'b1 && c < limit) begin
         @(negedge clk);
         c++;
      end
      check(name, 32'(dump_busy), 32'd0);
   endtask

   initial begin
      int cnt;
      int c;
      logic [AW-1:0] a;
      reset = 1'b0; csel = 3'b000; crd = 1'b0; caddr_rd = '0; cwr = 1'b0;
      caddr_wr = '0; cdata_wr = '0; dump_start = 1'b0; dump_sel = 3'b000; dump_ready = 1'b0;

      // 1: reset values, write then read
      repeat (3) @(negedge clk);
      check("rst_cdata_rd", 32'(cdata_rd), 32'd0);
      check("rst_wr_seen", 32'(wr_seen), 32'd0);
      check("rst_addr_err", 32'(addr_err), 32'd0);
      check("rst_dump_valid", 32'(dump_valid), 32'd0);
      check("rst_dump_addr", 32'(dump_addr), 32'd0);
      check("rst_dump_data", 32'(dump_data), 32'd0);
      check("rst_dump_busy", 32'(dump_busy), 32'd0);
      reset = 1'b1;
      write_word(3'b001, 12'd5, 20'h12345);
      read_word(3'b001, 12'd5, 20'h12345);
      check("wr_seen_l0", 32'(wr_seen), 32'd1);
      @(negedge clk);
      check("cdata_rd_hold", 32'(cdata_rd), 32'h12345);

      // 2: out-of-range access on L1
      write_word(3'b011, 12'd1023, 20'h11111);
      check("addr_err_clean", 32'(addr_err), 32'd0);
      write_word(3'b011, 12'd1024, 20'hABCDE);
      check("addr_err_oor", 32'(addr_err), 32'd1);
      read_word(3'b011, 12'd1024, 20'h00000);
      read_word(3'b011, 12'd1023, 20'h11111);
      check("wr_seen_l1", 32'(wr_seen), 32'd3);

      // 3: same-cycle read and write
      write_word(3'b101, 12'd7, 20'h00001);
      @(negedge clk);
      csel = 3'b101; cwr = 1'b1; crd = 1'b1; caddr_wr = 12'd7; caddr_rd = 12'd7; cdata_wr = 20'h00002;
`ifdef CONV_MEM_BYPASS_EN
      rd_exp_q.push_back(20'h00002);
`else
      rd_exp_q.push_back(20'h00001);
`endif
      @(negedge clk);
      cwr = 1'b0; crd = 1'b0;
      read_word(3'b101, 12'd7, 20'h00002);
      check("wr_seen_all", 32'(wr_seen), 32'd7);
      read_word(3'b110, 12'd0, 20'h00000);
      read_word(3'b101, 12'd2048, 20'h00000);

      // 4: full dump of bank 100 with ready held high
      for (int i = 0; i < 1024; i++) begin
         a = 12'(i);
         write_word(3'b100, a, 20'(i));
         dump_exp_q.push_back({a, 20'(i)});
      end
      dump_ready = 1'b1;
      start_dump(3'b100);
      check("dump4_busy", 32'(dump_busy), 32'd1);
      cnt = 1;
      while (dump_busy === 1'b1 && cnt < 5000) begin
         dump_start = (cnt == 100);
         dump_sel = 3'b001;
         @(negedge clk);
         if (dump_busy === 1'b1) cnt++;
      end
      dump_start = 1'b0;
      check("dump4_cycles", 32'(cnt), 32'd2048);
      check("dump4_drained", 32'(dump_exp_q.size()), 32'd0);
      check("dump4_valid_low", 32'(dump_valid), 32'd0);

      // 5: bank 001 dump with toggling ready and competing CONV reads
      for (int i = 0; i < 4096; i++) begin
         a = 12'(i);
         write_word(3'b001, a, {a, 8'hA5});
         dump_exp_q.push_back({a, a, 8'hA5});
      end
      dump_ready = 1'b0;
      start_dump(3'b001);
      c = 0;
      while (dump_busy === 1'b1 && c < 40000) begin
         dump_ready = c[0];
         if (c % 3 == 0) begin
            a = 12'(c % 4096);
            csel = 3'b001; crd = 1'b1; caddr_rd = a;
            rd_exp_q.push_back({a, 8'hA5});
         end else begin
            crd = 1'b0;
         end
         @(negedge clk);
         c++;
      end
      crd = 1'b0;
      check("dump5_done", 32'(dump_busy), 32'd0);
      check("dump5_drained", 32'(dump_exp_q.size()), 32'd0);
      check("rd5_drained", 32'(rd_exp_q.size()), 32'd0);

      // 6: reset mid-dump, then restart
      for (int i = 0; i < 1024; i++) dump_exp_q.push_back({12'(i), 20'(i)});
      dump_ready = 1'b1;
      start_dump(3'b100);
      c = 0;
      while (!(dump_valid === 1'b1 && dump_addr == 12'd300) && c < 2000) begin
         @(negedge clk);
         c++;
      end
      check("dump6_reach300", 32'(dump_addr), 32'd300);
      reset = 1'b0;
      #1;
      check("abort_valid", 32'(dump_valid), 32'd0);
      check("abort_busy", 32'(dump_busy), 32'd0);
      check("abort_pending", 32'(dump_exp_q.size()), 32'd724);
      dump_exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check("rst2_addr_err", 32'(addr_err), 32'd0);
      check("rst2_wr_seen", 32'(wr_seen), 32'd0);
      start_dump(3'b111);
      check("bad_sel_err", 32'(addr_err), 32'd1);
      check("bad_sel_busy", 32'(dump_busy), 32'd0);
      for (int i = 0; i < 1024; i++) dump_exp_q.push_back({12'(i), 20'(i)});
      start_dump(3'b100);
      check("restart_busy", 32'(dump_busy), 32'd1);
      wait_dump_done("dump6_done", 5000);
      check("dump6_drained", 32'(dump_exp_q.size()), 32'd0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
